// File: rtl/glay_setup_request_arbiter.sv
// ============================================================================
// glay_setup_request_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter sharing the single setup cache-request path between
// NUM_REQUESTORS request generators (serial read engines and similar). It
// sits in front of the request-out FIFO of the kernel setup stage.
//
// One requestor is granted at a time. The grant is held for at most
// MAX_BURST accepted beats, then released so the next requestor in
// round-robin order can win. Every accepted beat goes through one output
// register and carries the ID of the requestor it came from.
//
// Ports:
//   ap_clk           in   kernel clock, rising edge
//   ap_rst_n         in   asynchronous active-low reset
//   arbiter_enable   in   0 = issue no new grants, drop all ready outputs
//   req_valid        in   [NUM_REQUESTORS]  per-requestor request valid
//   req_payload      in   [NUM_REQUESTORS*PAYLOAD_WIDTH] packed payloads,
//                         requestor i at [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
//   req_ready        out  [NUM_REQUESTORS]  per-requestor accept (one-hot or 0)
//   out_almost_full  in   downstream FIFO prog_full, stalls acceptance
//   out_valid        out  registered write enable toward the FIFO
//   out_payload      out  [PAYLOAD_WIDTH] registered payload of accepted beat
//   out_grant_id     out  [ID_WIDTH] requestor index of the beat on out_payload
//   arbiter_busy     out  high while a grant is held or out_valid is high
//
// Headroom: a beat may already sit in the output register when
// out_almost_full rises, so the FIFO threshold must leave at least two free
// entries. Beats are never dropped except by reset.
// ============================================================================
module glay_setup_request_arbiter #(
    parameter int NUM_REQUESTORS = 4,
    parameter int PAYLOAD_WIDTH  = 512,
    parameter int MAX_BURST      = 8,
    parameter int ID_WIDTH       = (NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1
) (
    input  logic                                     ap_clk,
    input  logic                                     ap_rst_n,
    input  logic                                     arbiter_enable,
    input  logic [NUM_REQUESTORS-1:0]                req_valid,
    input  logic [NUM_REQUESTORS*PAYLOAD_WIDTH-1:0]  req_payload,
    output logic [NUM_REQUESTORS-1:0]                req_ready,
    input  logic                                     out_almost_full,
    output logic                                     out_valid,
    output logic [PAYLOAD_WIDTH-1:0]                 out_payload,
    output logic [ID_WIDTH-1:0]                      out_grant_id,
    output logic                                     arbiter_busy
);

    // beat_cnt must be able to count up to MAX_BURST-1 before release.
    localparam int                   CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(MAX_BURST - 1);
    // Pointer starts at the last index so requestor 0 wins first.
    localparam logic [ID_WIDTH-1:0]  PTR_RESET = ID_WIDTH'(NUM_REQUESTORS - 1);

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    arb_state_t                 r_state;
    logic [ID_WIDTH-1:0]        r_last_grant;
    logic [ID_WIDTH-1:0]        r_grant_id;
    logic [CNT_W-1:0]           r_beat_cnt;
    logic                       r_out_valid;
    logic [PAYLOAD_WIDTH-1:0]   r_out_payload;
    logic [ID_WIDTH-1:0]        r_out_grant_id;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                       w_gnt_valid;
    logic [PAYLOAD_WIDTH-1:0]   w_gnt_payload;
    logic                       w_ready_ok;
    logic                       w_xfer;
    logic                       w_release;
    logic                       w_start;
    logic                       w_scan_found;
    logic [ID_WIDTH-1:0]        w_scan_id;

    // Select valid and payload of the currently granted requestor. A
    // compare-per-index mux keeps every index a constant, so a grant ID
    // can never address outside the packed vectors.
    always_comb begin
        w_gnt_valid   = 1'b0;
        w_gnt_payload = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            if (r_grant_id == ID_WIDTH'(i)) begin
                w_gnt_valid   = req_valid[i];
                w_gnt_payload = req_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
    end

    // Round-robin scan starting at last_grant+1 with explicit wrap: the
    // first pass covers indices above the pointer, the second pass wraps
    // around to indices at or below it. The first hit overall wins.
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_id    = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            if (!w_scan_found && req_valid[i] && (ID_WIDTH'(i) > r_last_grant)) begin
                w_scan_found = 1'b1;
                w_scan_id    = ID_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            if (!w_scan_found && req_valid[i] && (ID_WIDTH'(i) <= r_last_grant)) begin
                w_scan_found = 1'b1;
                w_scan_id    = ID_WIDTH'(i);
            end
        end
    end

    // Ready depends only on registered state plus the two global stall
    // inputs, never on req_valid, so there is no valid->ready loop.
    assign w_ready_ok = (r_state == ARB_GRANT) && arbiter_enable && !out_almost_full;
    assign w_xfer     = w_ready_ok && w_gnt_valid;

    // Stall by out_almost_full while the holder is still valid keeps the
    // grant; dropping valid or disabling the arbiter gives it up.
    assign w_release  = (r_state == ARB_GRANT) &&
                        ((w_xfer && (r_beat_cnt == LAST_BEAT)) ||
                         !w_gnt_valid ||
                         !arbiter_enable);

    assign w_start    = (r_state == ARB_IDLE) && arbiter_enable &&
                        (|req_valid) && !out_almost_full;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            req_ready[i] = w_ready_ok && (r_grant_id == ID_WIDTH'(i));
        end
    end

    // ------------------------------------------------------------------
    // FSM and output register
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state        <= ARB_IDLE;
            r_last_grant   <= PTR_RESET;
            r_grant_id     <= '0;
            r_beat_cnt     <= '0;
            r_out_valid    <= 1'b0;
            r_out_payload  <= '0;
            r_out_grant_id <= '0;
        end else begin
            // Output stage: a beat appears one cycle after its handshake;
            // the payload register holds its value across idle cycles.
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_payload  <= w_gnt_payload;
                r_out_grant_id <= r_grant_id;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_start) begin
                        r_grant_id <= w_scan_id;
                        r_beat_cnt <= '0;
                        r_state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    // The pointer moves only on release, so a grant that
                    // moved zero beats still passes priority on.
                    if (w_release) begin
                        r_state      <= ARB_IDLE;
                        r_last_grant <= r_grant_id;
                        r_beat_cnt   <= '0;
                    end else if (w_xfer) begin
                        r_beat_cnt   <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign out_payload  = r_out_payload;
    assign out_grant_id = r_out_grant_id;
    assign arbiter_busy = (r_state == ARB_GRANT) || r_out_valid;

endmodule

// File: tb/tb_glay_setup_request_arbiter.sv
module tb_glay_setup_request_arbiter;

    localparam int N  = 4;
    localparam int PW = 512;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic              arbiter_enable;
    logic [N-1:0]      req_valid;
    logic [N*PW-1:0]   req_payload;
    logic [N-1:0]      req_ready;
    logic              out_almost_full;
    logic              out_valid;
    logic [PW-1:0]     out_payload;
    logic [1:0]        out_grant_id;
    logic              arbiter_busy;

    glay_setup_request_arbiter #(
        .NUM_REQUESTORS (N),
        .PAYLOAD_WIDTH  (PW),
        .MAX_BURST      (8)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .arbiter_enable  (arbiter_enable),
        .req_valid       (req_valid),
        .req_payload     (req_payload),
        .req_ready       (req_ready),
        .out_almost_full (out_almost_full),
        .out_valid       (out_valid),
        .out_payload     (out_payload),
        .out_grant_id    (out_grant_id),
        .arbiter_busy    (arbiter_busy)
    );

    initial forever #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    // Source model: each requestor offers numbered beats while enabled and
    // it still has beats left.
    logic [N-1:0] src_en;
    int           src_seq  [N];
    int           src_left [N];
    int           exp_seq  [N];

    int           exp_id_q [$];
    logic [PW-1:0] exp_pl_q [$];

    logic [63:0]  ov;
    logic [63:0]  ov_exp;

    function automatic logic [PW-1:0] mk_pl(input int id, input int seq);
        logic [PW-1:0] p;
        p            = '0;
        p[31:0]      = 32'(seq);
        p[47:32]     = 16'(id);
        p[PW-1:PW-16] = 16'hA500 | 16'(id);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = src_en[i] && (src_left[i] != 0);
            req_payload[i*PW +: PW] = mk_pl(i, src_seq[i]);
        end
    endtask

    // Advance one clock: handshakes are sampled mid-cycle, sources advance
    // just after the edge, and the task returns 2 time units past the edge.
    task automatic step();
        logic [N-1:0] hs;
        @(negedge ap_clk);
        hs = req_valid & req_ready;
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                src_seq[i]++;
                src_left[i]--;
            end
        end
        drive();
        #1;
    endtask

    task automatic push_exp(input int id);
        exp_id_q.push_back(id);
        exp_pl_q.push_back(mk_pl(id, exp_seq[id]));
        exp_seq[id]++;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60 && exp_id_q.size() != 0; k++) step();
        chk(tag, PW'(exp_id_q.size()), '0);
    endtask

    // Asserts reset asynchronously, checks the outputs cleared at once,
    // then releases it just after an edge.
    task automatic do_reset();
        ap_rst_n        = 1'b0;
        src_en          = '0;
        arbiter_enable  = 1'b1;
        out_almost_full = 1'b0;
        for (int i = 0; i < N; i++) src_left[i] = 0;
        drive();
        #1;
        chk("rst_out_valid",    PW'(out_valid),    '0);
        chk("rst_out_payload",  out_payload,       '0);
        chk("rst_out_grant_id", PW'(out_grant_id), '0);
        chk("rst_req_ready",    PW'(req_ready),    '0);
        chk("rst_busy",         PW'(arbiter_busy), '0);
        exp_id_q.delete();
        exp_pl_q.delete();
        for (int i = 0; i < N; i++) exp_seq[i] = src_seq[i];
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        #1;
    endtask

    // Scoreboard: every output beat must match the head of the queue.
    always @(negedge ap_clk) begin
        if (ap_rst_n === 1'b1 && out_valid === 1'b1) begin
            chk("beat_expected", PW'(exp_id_q.size() != 0), PW'(1));
            if (exp_id_q.size() != 0) begin
                chk("beat_grant_id", PW'(out_grant_id), PW'(exp_id_q.pop_front()));
                chk("beat_payload",  out_payload,       exp_pl_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst_n        = 1'b1;
        arbiter_enable  = 1'b1;
        out_almost_full = 1'b0;
        src_en          = '0;
        req_valid       = '0;
        req_payload     = '0;
        for (int i = 0; i < N; i++) begin
            src_seq[i]  = 0;
            src_left[i] = 0;
            exp_seq[i]  = 0;
        end
        #2;

        // ---- A: single requestor 0, 20 beats, bursts of 8 -------------
        do_reset();
        src_en = 4'b0001; src_left[0] = 20; drive(); #1;
        for (int k = 0; k < 20; k++) push_exp(0);
        chk("A_ready_c0", PW'(req_ready), PW'(4'b0000));
        ov = '0; ov_exp = '0;
        ov[0] = out_valid;
        for (int c = 1; c <= 26; c++) begin
            step();
            ov[c] = out_valid;
            if (c == 1) chk("A_ready_c1", PW'(req_ready), PW'(4'b0001));
        end
        for (int c = 0; c <= 26; c++)
            ov_exp[c] = (c >= 2 && c <= 9) || (c >= 11 && c <= 18) || (c >= 20 && c <= 23);
        chk("A_valid_pattern", PW'(ov), PW'(ov_exp));
        drain("A_drain");

        // ---- B: all four requesting, 8 beats per grant, rotating --------
        do_reset();
        src_en = 4'b1111;
        src_left[0] = 16; src_left[1] = 8; src_left[2] = 8; src_left[3] = 8;
        drive(); #1;
        for (int g = 0; g < 5; g++)
            for (int k = 0; k < 8; k++) push_exp(g % 4);
        ov = '0; ov_exp = '0;
        ov[0] = out_valid;
        for (int c = 1; c <= 48; c++) begin
            step();
            ov[c] = out_valid;
        end
        for (int c = 0; c <= 48; c++)
            ov_exp[c] = (c >= 2) && (c <= 45) && (((c - 2) % 9) != 8);
        chk("B_valid_pattern", PW'(ov), PW'(ov_exp));
        drain("B_drain");

        // ---- C: out_almost_full stall during grant to requestor 2 -------
        do_reset();
        src_en = 4'b0100; src_left[2] = 10; drive(); #1;
        for (int k = 0; k < 10; k++) push_exp(2);
        repeat (4) step();
        chk("C_beat3_out", PW'(out_valid), PW'(1));
        out_almost_full = 1'b1; #1;
        for (int c = 4; c <= 8; c++) begin
            chk($sformatf("C_ready_stall_c%0d", c), PW'(req_ready), PW'(4'b0000));
            chk($sformatf("C_busy_stall_c%0d", c),  PW'(arbiter_busy), PW'(1));
            if (c > 4) chk($sformatf("C_valid_stall_c%0d", c), PW'(out_valid), '0);
            step();
        end
        chk("C_valid_c9", PW'(out_valid), '0);
        out_almost_full = 1'b0; #1;
        chk("C_ready_resume", PW'(req_ready), PW'(4'b0100));
        for (int c = 10; c <= 16; c++) begin
            step();
            chk($sformatf("C_valid_c%0d", c), PW'(out_valid), PW'(c != 15));
        end
        drain("C_drain");

        // ---- D: requestor 1 drops valid, 3 wins, then 1 again ----------
        do_reset();
        src_en = 4'b1010; src_left[1] = 3; src_left[3] = 5; drive(); #1;
        for (int k = 0; k < 3; k++) push_exp(1);
        for (int k = 0; k < 5; k++) push_exp(3);
        for (int k = 0; k < 4; k++) push_exp(1);
        repeat (5) step();
        src_left[1] = 4; drive(); #1;
        chk("D_ready_idle", PW'(req_ready),    PW'(4'b0000));
        chk("D_busy_idle",  PW'(arbiter_busy), '0);
        step();
        chk("D_ready_gnt3", PW'(req_ready), PW'(4'b1000));
        drain("D_drain");

        // ---- E: disable mid-burst, then reset mid-burst ---------------
        do_reset();
        src_en = 4'b0001; src_left[0] = 20; drive(); #1;
        for (int k = 0; k < 3; k++) push_exp(0);
        repeat (3) step();
        arbiter_enable = 1'b0; #1;
        chk("E_ready_disable", PW'(req_ready), PW'(4'b0000));
        chk("E_valid_c3",      PW'(out_valid), PW'(1));
        step();
        chk("E_busy_idle",     PW'(arbiter_busy), '0);
        arbiter_enable = 1'b1; #1;
        step();
        chk("E_ready_regrant", PW'(req_ready), PW'(4'b0001));
        step();
        step();
        chk("E_valid_midburst", PW'(out_valid), PW'(1));
        chk("E_queue_before_rst", PW'(exp_id_q.size()), '0);
        do_reset();
        src_en = 4'b1111;
        for (int i = 0; i < N; i++) src_left[i] = 1;
        drive(); #1;
        for (int i = 0; i < N; i++) push_exp(i);
        chk("E_ready_post_c0", PW'(req_ready), PW'(4'b0000));
        step();
        chk("E_ready_post_c1", PW'(req_ready), PW'(4'b0001));
        drain("E_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glay_setup_request_arbiter.md
Name: glay_setup_request_arbiter

Overview:
- Round-robin arbiter that shares the single setup cache-request path among NUM_REQUESTORS request generators (serial read engines and similar).
- Sits between the engines and the request-out FIFO of the kernel setup stage.
- Grants one requestor at a time, holds the grant for a bounded burst, then rotates.
- Forwards each accepted request through a registered output stage, tagged with the granted requestor's ID.

Parameters:
- NUM_REQUESTORS, 4, number of competing request sources (≥1).
- PAYLOAD_WIDTH, 512, width of one request payload in bits.
- MAX_BURST, 8, maximum beats accepted per grant before forced rotation (≥1).
- ID_WIDTH, $clog2(NUM_REQUESTORS) (min 1), width of the grant ID.

Ports:
- ap_clk  in  1  kernel clock; all logic on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- arbiter_enable  in  1  level; when 0 no new grants are issued and all ready outputs drop.
- req_valid  in  NUM_REQUESTORS  per-requestor request valid.
- req_payload  in  NUM_REQUESTORS*PAYLOAD_WIDTH  packed payloads; requestor i occupies bits [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH].
- req_ready  out  NUM_REQUESTORS  per-requestor accept; at most one bit set.
- out_almost_full  in  1  downstream FIFO prog_full; asserting it stalls acceptance.
- out_valid  out  1  registered request valid toward the FIFO (drives wr_en).
- out_payload  out  PAYLOAD_WIDTH  registered payload of the accepted beat.
- out_grant_id  out  ID_WIDTH  requestor index of the beat on out_payload.
- arbiter_busy  out  1  high while in state ARB_GRANT or while out_valid is high.

Behaviour:
- Reset (ap_rst_n=0, async):
  - state=ARB_IDLE; last_grant=NUM_REQUESTORS-1, so requestor 0 has first priority.
  - beat_cnt=0; grant_id=0.
  - out_valid=0, out_payload=0, out_grant_id=0, req_ready=0, arbiter_busy=0.
- Reset release: first arbitration can occur on the first clock edge after deassertion.
- Reset mid-burst: in-flight beat is dropped, state returns to ARB_IDLE, pointer returns to its reset value.
- State ARB_IDLE:
  - req_ready=0.
  - If arbiter_enable && |req_valid && !out_almost_full: choose the first i with req_valid[i], scanning from last_grant+1 modulo NUM_REQUESTORS.
  - Register grant_id=i, beat_cnt=0, go to ARB_GRANT.
  - Otherwise stay in ARB_IDLE.
- State ARB_GRANT:
  - req_ready[grant_id] = arbiter_enable && !out_almost_full (combinational from registered state); all other bits are 0.
  - Transfer happens when req_valid[grant_id] && req_ready[grant_id].
  - On transfer: next edge sets out_valid=1, out_payload=req_payload[grant_id], out_grant_id=grant_id, beat_cnt+=1.
  - Without a transfer: out_valid=0 next cycle; out_payload holds.
  - Release to ARB_IDLE (last_grant<=grant_id, beat_cnt<=0) when any of these holds:
    - a transfer with beat_cnt==MAX_BURST-1;
    - req_valid[grant_id]==0;
    - arbiter_enable==0.
  - out_almost_full=1 while req_valid[grant_id]=1: grant and beat_cnt are held, no release, ready=0.
  - A requestor dropping valid for one cycle loses the grant; it re-competes in the next arbitration.
- Latency:
  - valid asserted in IDLE at cycle t → grant registered at t+1 → ready high during t+1 → out_valid at t+2.
  - Sustained throughput is 1 beat/cycle within a burst.
  - There is exactly one IDLE bubble cycle between consecutive grants.
- Downstream headroom: one beat may be in the output register when out_almost_full rises, so the downstream prog_full threshold must leave ≥2 free entries. The arbiter never drops a beat.
- The round-robin pointer updates only on release, so a requestor that is granted but sends zero beats still rotates priority.
- NUM_REQUESTORS=1: pointer is constant, ID_WIDTH=1, out_grant_id=0.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - Modulo wrap of the scan index is explicit; no out-of-range index is ever generated.

Test Plan:
- Reset, then req_valid=4'b0001 continuously, 20 beats, MAX_BURST=8 → grant 0:
  - out_valid first at cycle 2;
  - beats arrive in runs of 8, each run followed by 1 bubble;
  - out_grant_id=0 throughout.
- req_valid=4'b1111 held, payload=ID → out_grant_id sequence is 8×0, 8×1, 8×2, 8×3, 8×0, …, with exactly one bubble between groups.
- During a grant to requestor 2, hold out_almost_full=1 for 5 cycles after beat 3 → req_ready=0 for those 5 cycles, no out_valid, grant held; beats 4–8 then resume, still ID 2.
- Requestor 1 drops valid after 3 beats while 4'b1010 is requesting → release; next grant goes to 3 (not 1), then back to 1.
- Deassert arbiter_enable mid-burst, then deassert ap_rst_n mid-burst → ready drops the same cycle and the state returns to IDLE; on reset all outputs read 0 immediately (asynchronously) and the first post-reset grant goes to requestor 0.
